femtosoc_uart: RTL

Memory-mapped 8N1 UART that acts as a responder on the SoC iomem bus. It completes CPU load/store transactions to a 16-byte register window. It serialises bytes from a small TX FIFO onto ser_tx and deserialises ser_rx into a one-entry RX holding register. It sits beside the CPU in the iomem address space (addr[31:24] != 0).

---
 rtl/femtosoc_uart.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/femtosoc_uart.sv
// Memory-mapped 8N1 UART responder for the SoC iomem bus: DIV / DATA / STATUS
// registers, a small TX FIFO feeding the serialiser, and a one-entry RX holding register.
module femtosoc_uart #(
    parameter logic [31:0] BASE_ADDR     = 32'h0200_0000,
    parameter logic [15:0] DEFAULT_DIV   = 16'd104,
    parameter int unsigned TX_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        ser_tx,
    input  logic        ser_rx
);
    localparam int unsigned AW = $clog2(TX_FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] div_q, div_d;

    logic [7:0]    fifo_q [TX_FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q, cnt_d;

    uart_state_e tx_state_q, tx_state_d;
    logic [15:0] tx_tmr_q, tx_tmr_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_out_q, tx_out_d;

    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    uart_state_e rx_state_q, rx_state_d;
    logic [15:0] rx_tmr_q, rx_tmr_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, rx_ferr_q, rx_ferr_d;

    logic        sel, is_wr, fire, stall, push, pop, rd_clear;
    logic        tx_full, tx_empty, tx_idle, rx_store, rx_ovr_set, rx_ferr_set;
    logic [1:0]  off, w1c;
    logic [15:0] per, half;
    logic        unused_ok;

    assign unused_ok = ^{iomem_addr[1:0], iomem_wdata[31:16]};

    assign sel      = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4]);
    assign off      = iomem_addr[3:2];
    assign is_wr    = |iomem_wstrb;
    assign tx_full  = (cnt_q == CW'(TX_FIFO_DEPTH));
    assign tx_empty = (cnt_q == '0);
    assign tx_idle  = tx_empty && (tx_state_q == S_IDLE);
    assign stall    = (off == 2'd1) && is_wr && tx_full;
    assign fire     = sel && !ready_q && !stall;
    assign push     = fire && (off == 2'd1) && is_wr;
    assign per      = (div_q < 16'd2) ? 16'd2 : div_q;
    assign half     = per >> 1;

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign ser_tx      = tx_out_q;

    always_comb begin
        ready_d  = fire;
        rdata_d  = '0;
        div_d    = div_q;
        rd_clear = 1'b0;
        w1c      = '0;
        if (fire) begin
            unique case (off)
                2'd0: begin
                    if (!is_wr) rdata_d = {16'h0, div_q};
                    if (iomem_wstrb[0]) div_d[7:0]  = iomem_wdata[7:0];
                    if (iomem_wstrb[1]) div_d[15:8] = iomem_wdata[15:8];
                end
                2'd1: begin
                    if (!is_wr) begin
                        rdata_d  = rx_valid_q ? {24'h0, rx_byte_q} : '1;
                        rd_clear = rx_valid_q;
                    end
                end
                2'd2: begin
                    if (!is_wr) rdata_d = {27'h0, rx_ferr_q, rx_ovr_q, rx_valid_q, tx_idle, tx_full};
                    if (iomem_wstrb[0]) w1c = iomem_wdata[4:3];
                end
                default: ;
            endcase
        end
    end

    // STOP pops straight into the next START so queued bytes leave with no idle gap.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tmr_d   = tx_tmr_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_out_d   = tx_out_q;
        pop        = 1'b0;
        unique case (tx_state_q)
            S_IDLE: begin
                if (!tx_empty) begin
                    pop        = 1'b1;
                    tx_shift_d = fifo_q[rptr_q];
                    tx_out_d   = 1'b0;
                    tx_tmr_d   = per - 16'd1;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_tmr_q == '0) begin
                    tx_state_d = S_DATA;
                    tx_out_d   = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = '0;
                    tx_tmr_d   = per - 16'd1;
                end else tx_tmr_d = tx_tmr_q - 16'd1;
            end
            S_DATA: begin
                if (tx_tmr_q == '0) begin
                    tx_tmr_d = per - 16'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = S_STOP;
                        tx_out_d   = 1'b1;
                    end else begin
                        tx_out_d   = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end else tx_tmr_d = tx_tmr_q - 16'd1;
            end
            S_STOP: begin
                if (tx_tmr_q == '0) begin
                    if (!tx_empty) begin
                        pop        = 1'b1;
                        tx_shift_d = fifo_q[rptr_q];
                        tx_out_d   = 1'b0;
                        tx_tmr_d   = per - 16'd1;
                        tx_state_d = S_START;
                    end else tx_state_d = S_IDLE;
                end else tx_tmr_d = tx_tmr_q - 16'd1;
            end
            default: tx_state_d = S_IDLE;
        endcase
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_tmr_d    = rx_tmr_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_store    = 1'b0;
        rx_ovr_set  = 1'b0;
        rx_ferr_set = 1'b0;
        unique case (rx_state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = S_START;
                    rx_tmr_d   = half - 16'd1;
                end
            end
            S_START: begin
                if (rx_tmr_q == '0) begin
                    rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                    rx_tmr_d   = per - 16'd1;
                    rx_bit_d   = '0;
                end else rx_tmr_d = rx_tmr_q - 16'd1;
            end
            S_DATA: begin
                if (rx_tmr_q == '0) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_tmr_d   = per - 16'd1;
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                end else rx_tmr_d = rx_tmr_q - 16'd1;
            end
            S_STOP: begin
                if (rx_tmr_q == '0) begin
                    rx_state_d = S_IDLE;
                    if (!rx_s2_q) rx_ferr_set = 1'b1;
                    else if (!rx_valid_q || rd_clear) rx_store = 1'b1;
                    else rx_ovr_set = 1'b1;
                end else rx_tmr_d = rx_tmr_q - 16'd1;
            end
            default: rx_state_d = S_IDLE;
        endcase
        // Flag sets take priority over a same-cycle read clear or W1C.
        rx_byte_d  = rx_store ? rx_shift_q : rx_byte_q;
        rx_valid_d = rx_store || (rx_valid_q && !rd_clear);
        rx_ovr_d   = (rx_ovr_q && !w1c[0]) || rx_ovr_set;
        rx_ferr_d  = (rx_ferr_q && !w1c[1]) || rx_ferr_set;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= iomem_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            div_q      <= DEFAULT_DIV;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            tx_state_q <= S_IDLE;
            tx_tmr_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_out_q   <= 1'b1;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_tmr_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            div_q      <= div_d;
            wptr_q     <= wptr_q + AW'(push);
            rptr_q     <= rptr_q + AW'(pop);
            cnt_q      <= cnt_d;
            tx_state_q <= tx_state_d;
            tx_tmr_q   <= tx_tmr_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_out_q   <= tx_out_d;
            rx_s1_q    <= ser_rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_tmr_q   <= rx_tmr_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end
endmodule
